// File: rtl/wave_capture_if.sv
// rtl/wave_capture_if.sv - sample stream, display handshake and wave RAM write port
interface wave_capture_if #(
  parameter int SAMPLE_W = 16
);
  logic                new_sample_ready;
  logic [SAMPLE_W-1:0] new_sample_in;
  logic                wave_display_idle;
  logic [8:0]          write_address;
  logic                write_enable;
  logic [7:0]          write_sample;
  logic                read_index;

  // master: the capture engine; slave: audio source, display and wave RAM side
  modport master (
    input  new_sample_ready,
    input  new_sample_in,
    input  wave_display_idle,
    output write_address,
    output write_enable,
    output write_sample,
    output read_index
  );

  modport slave (
    output new_sample_ready,
    output new_sample_in,
    output wave_display_idle,
    input  write_address,
    input  write_enable,
    input  write_sample,
    input  read_index
  );
endinterface

// File: rtl/wave_capture.sv
// rtl/wave_capture.sv - zero-crossing triggered 256-sample capture into the idle wave RAM half
module wave_capture #(
  parameter int SAMPLE_W     = 16,
  parameter int TRIG_TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  wave_capture_if.master bus
);

  localparam int TCW = (TRIG_TIMEOUT > 1) ? $clog2(TRIG_TIMEOUT) : 1;
  localparam logic [TCW-1:0] TC_LAST = TCW'(TRIG_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } state_e;

  state_e          state_q;
  logic            read_index_q;
  logic            write_enable_q;
  logic [8:0]      write_address_q;
  logic [7:0]      write_sample_q;
  logic [7:0]      count_q;
  logic [TCW-1:0]  tcnt_q;
  logic            prev_neg_q;

  logic            strobe;
  logic            sample_neg;
  logic            crossing;
  logic            timeout_hit;
  logic            tcnt_can_inc;
  logic [7:0]      write_sample_d;
  logic            unused_low_bits;

  always_comb begin
    strobe          = bus.new_sample_ready;
    sample_neg      = bus.new_sample_in[SAMPLE_W-1];
    crossing        = prev_neg_q & ~sample_neg;
    timeout_hit     = (TRIG_TIMEOUT != 0) && (tcnt_q == TC_LAST);
    // With the timeout disabled the counter just pins at its maximum
    tcnt_can_inc    = (TRIG_TIMEOUT != 0) || (tcnt_q != {TCW{1'b1}});
    // Adding 128 to the top byte is the same as flipping its sign bit
    write_sample_d  = {~bus.new_sample_in[SAMPLE_W-1], bus.new_sample_in[SAMPLE_W-2 -: 7]};
    unused_low_bits = ^bus.new_sample_in[SAMPLE_W-9:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= ARMED;
      read_index_q    <= 1'b0;
      write_enable_q  <= 1'b0;
      write_address_q <= 9'h100;
      write_sample_q  <= 8'h00;
      count_q         <= 8'd0;
      tcnt_q          <= '0;
      prev_neg_q      <= 1'b0;
    end else begin
      write_enable_q <= 1'b0;
      if (strobe) begin
        prev_neg_q <= sample_neg;
      end

      case (state_q)
        ARMED: begin
          if (strobe) begin
            if (crossing || timeout_hit) begin
              write_enable_q  <= 1'b1;
              write_address_q <= {~read_index_q, 8'd0};
              write_sample_q  <= write_sample_d;
              count_q         <= 8'd1;
              tcnt_q          <= '0;
              state_q         <= ACTIVE;
            end else if (tcnt_can_inc) begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
        end

        ACTIVE: begin
          if (strobe) begin
            write_enable_q  <= 1'b1;
            write_address_q <= {~read_index_q, count_q};
            write_sample_q  <= write_sample_d;
            count_q         <= count_q + 8'd1;
            if (count_q == 8'hFF) begin
              state_q <= WAIT;
            end
          end
        end

        // A strobe landing together with the swap is not trigger-evaluated
        WAIT: begin
          if (bus.wave_display_idle) begin
            read_index_q <= ~read_index_q;
            state_q      <= ARMED;
          end
        end

        default: begin
          state_q <= ARMED;
        end
      endcase
    end
  end

  assign bus.write_enable  = write_enable_q;
  assign bus.write_address = write_address_q;
  assign bus.write_sample  = write_sample_q;
  assign bus.read_index    = read_index_q;

endmodule
